// File: rtl/vga_fetch_pkg.sv
// Shared widths, default memory map and fetch-pass state type for the VGA sample scheduler.
package vga_fetch_pkg;

  localparam int unsigned ADDR_W = 12;
  localparam int unsigned DATA_W = 32;

  localparam logic [ADDR_W-1:0] ECG_BASE_DEF = 12'h559;
  localparam logic [ADDR_W-1:0] EMG_BASE_DEF = 12'h6AD;
  localparam logic [ADDR_W-1:0] BPM_ADDR_DEF = 12'd1704;

  typedef enum logic [2:0] {
    IDLE,
    FETCH_ECG,
    FETCH_EMG,
    FETCH_BPM,
    CONVERT
  } fetch_state_t;

endpackage

// File: rtl/bpm_bin2bcd.sv
// 10-bit binary to three BCD digits by repeated subtraction; digits change only on completion.
module bpm_bin2bcd (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_start,
  input  logic [9:0] i_bin,
  output logic       o_done,
  output logic [3:0] o_hundreds,
  output logic [3:0] o_tens,
  output logic [3:0] o_ones
);

  logic       r_active;
  logic       r_tens_phase;
  logic [9:0] r_val;
  logic [3:0] r_hund;
  logic [3:0] r_tens;
  logic [3:0] r_hund_q;
  logic [3:0] r_tens_q;
  logic [3:0] r_ones_q;

  // Done is combinational so the parent can retire in the same edge the digits load.
  assign o_done     = r_active & r_tens_phase & (r_val < 10'd10);
  assign o_hundreds = r_hund_q;
  assign o_tens     = r_tens_q;
  assign o_ones     = r_ones_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_active     <= 1'b0;
      r_tens_phase <= 1'b0;
      r_val        <= '0;
      r_hund       <= '0;
      r_tens       <= '0;
      r_hund_q     <= '0;
      r_tens_q     <= '0;
      r_ones_q     <= '0;
    end else if (i_start) begin
      r_active     <= 1'b1;
      r_tens_phase <= 1'b0;
      r_val        <= i_bin;
      r_hund       <= '0;
      r_tens       <= '0;
    end else if (r_active) begin
      if (!r_tens_phase) begin
        if (r_val >= 10'd100) begin
          r_val  <= r_val - 10'd100;
          r_hund <= r_hund + 4'd1;
        end else begin
          r_tens_phase <= 1'b1;
        end
      end else if (r_val >= 10'd10) begin
        r_val  <= r_val - 10'd10;
        r_tens <= r_tens + 4'd1;
      end else begin
        r_active <= 1'b0;
        r_hund_q <= r_hund;
        r_tens_q <= r_tens;
        r_ones_q <= r_val[3:0];
      end
    end
  end

endmodule

// File: rtl/vga_sample_scheduler.sv
// Per-frame fetch of ECG/EMG sample windows and periodic BPM word over a CPU-priority shared read port.
module vga_sample_scheduler
  import vga_fetch_pkg::*;
#(
  parameter int unsigned       SAMPLE_COUNT   = 335,
  parameter logic [ADDR_W-1:0] ECG_BASE       = ECG_BASE_DEF,
  parameter logic [ADDR_W-1:0] EMG_BASE       = EMG_BASE_DEF,
  parameter logic [ADDR_W-1:0] BPM_ADDR       = BPM_ADDR_DEF,
  parameter int unsigned       FRAMES_PER_BPM = 60
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_frame_start,
  input  logic              i_cpu_req,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_cpu_grant,
  output logic              o_buf_we,
  output logic              o_buf_sel,
  output logic [8:0]        o_buf_waddr,
  output logic [7:0]        o_buf_wdata,
  output logic [3:0]        o_bpm_hundreds,
  output logic [3:0]        o_bpm_tens,
  output logic [3:0]        o_bpm_ones,
  output logic              o_bpm_valid,
  output logic              o_busy,
  output logic              o_overrun
);

  localparam int unsigned       CNT_W    = (FRAMES_PER_BPM > 1) ? $clog2(FRAMES_PER_BPM) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(FRAMES_PER_BPM - 1);
  localparam logic [8:0]        LAST_IDX = 9'(SAMPLE_COUNT - 1);
  localparam logic [DATA_W-1:0] BPM_MAX  = DATA_W'(999);

  fetch_state_t     r_state;
  logic [8:0]       r_idx;
  logic             r_drain;
  logic             r_bpm_pass;
  logic             r_bpm_issued;
  logic [CNT_W-1:0] r_frame_cnt;
  logic             r_inflight;
  logic             r_buf_sel;
  logic [8:0]       r_buf_waddr;
  logic             r_busy;
  logic             r_overrun;
  logic             r_bpm_valid;

  logic              w_fetching;
  logic              w_issue;
  logic [ADDR_W-1:0] w_issue_addr;
  logic              w_conv_start;
  logic [9:0]        w_conv_bin;
  logic              w_conv_done;

  always_comb begin
    w_fetching   = 1'b0;
    w_issue_addr = '0;
    case (r_state)
      FETCH_ECG: begin
        w_fetching   = 1'b1;
        w_issue_addr = ECG_BASE + {3'b000, r_idx};
      end
      FETCH_EMG: begin
        w_fetching   = !r_drain;
        w_issue_addr = EMG_BASE + {3'b000, r_idx};
      end
      FETCH_BPM: begin
        w_fetching   = !r_bpm_issued;
        w_issue_addr = BPM_ADDR;
      end
      default: ;
    endcase
  end

  assign w_issue     = w_fetching & !i_cpu_req & !i_reset;
  assign o_mem_addr  = w_issue ? w_issue_addr : i_cpu_addr;
  assign o_cpu_grant = !w_issue;

  assign w_conv_start = (r_state == FETCH_BPM) && r_bpm_issued;
  assign w_conv_bin   = (i_mem_rdata > BPM_MAX) ? 10'd999 : i_mem_rdata[9:0];

  assign o_buf_we    = r_inflight;
  assign o_buf_sel   = r_buf_sel;
  assign o_buf_waddr = r_buf_waddr;
  // Read data arrives in the write cycle; gating keeps the bus at zero between writes.
  assign o_buf_wdata = r_inflight ? i_mem_rdata[11:4] : '0;
  assign o_busy      = r_busy;
  assign o_overrun   = r_overrun;
  assign o_bpm_valid = r_bpm_valid;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= IDLE;
      r_idx        <= '0;
      r_drain      <= 1'b0;
      r_bpm_pass   <= 1'b0;
      r_bpm_issued <= 1'b0;
      r_frame_cnt  <= '0;
      r_inflight   <= 1'b0;
      r_buf_sel    <= 1'b0;
      r_buf_waddr  <= '0;
      r_busy       <= 1'b0;
      r_overrun    <= 1'b0;
      r_bpm_valid  <= 1'b0;
    end else begin
      r_inflight <= w_issue && (r_state != FETCH_BPM);
      if (w_issue && (r_state != FETCH_BPM)) begin
        r_buf_waddr <= r_idx;
        r_buf_sel   <= (r_state == FETCH_EMG);
      end
      if (i_frame_start && r_busy) r_overrun <= 1'b1;

      case (r_state)
        IDLE: begin
          if (i_frame_start) begin
            r_state     <= FETCH_ECG;
            r_busy      <= 1'b1;
            r_idx       <= '0;
            r_drain     <= 1'b0;
            r_bpm_pass  <= (r_frame_cnt == '0);
            r_frame_cnt <= (r_frame_cnt == CNT_LAST) ? '0 : r_frame_cnt + CNT_W'(1);
          end
        end
        FETCH_ECG: begin
          if (w_issue) begin
            if (r_idx == LAST_IDX) begin
              r_state <= FETCH_EMG;
              r_idx   <= '0;
            end else begin
              r_idx <= r_idx + 9'd1;
            end
          end
        end
        FETCH_EMG: begin
          if (w_issue) begin
            if (r_idx == LAST_IDX) r_drain <= 1'b1;
            else                   r_idx   <= r_idx + 9'd1;
          end
          if (r_drain && !r_inflight) begin
            r_bpm_issued <= 1'b0;
            if (r_bpm_pass) begin
              r_state <= FETCH_BPM;
            end else begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
        FETCH_BPM: begin
          if (w_issue)      r_bpm_issued <= 1'b1;
          if (w_conv_start) r_state      <= CONVERT;
        end
        CONVERT: begin
          if (w_conv_done) begin
            r_state     <= IDLE;
            r_busy      <= 1'b0;
            r_bpm_valid <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  bpm_bin2bcd u_bcd (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_start    (w_conv_start),
    .i_bin      (w_conv_bin),
    .o_done     (w_conv_done),
    .o_hundreds (o_bpm_hundreds),
    .o_tens     (o_bpm_tens),
    .o_ones     (o_bpm_ones)
  );

endmodule

// File: tb/tb_vga_sample_scheduler.sv
// Bench for vga_sample_scheduler: memory model, expected read/write stream, digit and pass-length checks.
module tb_vga_sample_scheduler;

  localparam int unsigned SC       = 335;
  localparam logic [11:0] ECG_B    = 12'h559;
  localparam logic [11:0] EMG_B    = 12'h6AD;
  localparam logic [11:0] BPM_A    = 12'd1704;
  localparam int unsigned BPM_EVERY = 60;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_start;
  logic        cpu_req;
  logic [11:0] cpu_addr;
  logic [31:0] mem_rdata;
  logic [11:0] mem_addr;
  logic        cpu_grant;
  logic        buf_we;
  logic        buf_sel;
  logic [8:0]  buf_waddr;
  logic [7:0]  buf_wdata;
  logic [3:0]  d_h, d_t, d_o;
  logic        bpm_valid;
  logic        busy;
  logic        overrun;

  vga_sample_scheduler #(
    .SAMPLE_COUNT   (SC),
    .ECG_BASE       (ECG_B),
    .EMG_BASE       (EMG_B),
    .BPM_ADDR       (BPM_A),
    .FRAMES_PER_BPM (BPM_EVERY)
  ) dut (
    .i_clk          (clk),
    .i_reset        (reset),
    .i_frame_start  (frame_start),
    .i_cpu_req      (cpu_req),
    .i_cpu_addr     (cpu_addr),
    .i_mem_rdata    (mem_rdata),
    .o_mem_addr     (mem_addr),
    .o_cpu_grant    (cpu_grant),
    .o_buf_we       (buf_we),
    .o_buf_sel      (buf_sel),
    .o_buf_waddr    (buf_waddr),
    .o_buf_wdata    (buf_wdata),
    .o_bpm_hundreds (d_h),
    .o_bpm_tens     (d_t),
    .o_bpm_ones     (d_o),
    .o_bpm_valid    (bpm_valid),
    .o_busy         (busy),
    .o_overrun      (overrun)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:4095];
  always @(posedge clk) mem_rdata <= mem[mem_addr];

  typedef struct {
    logic       sel;
    logic [8:0] idx;
    logic [7:0] data;
  } wr_t;

  logic [11:0] q_addr [$];
  wr_t         q_wr [$];
  int unsigned total = 0;
  int unsigned bad = 0;
  int unsigned wr_seen = 0;
  int unsigned pass_cnt = 0;
  bit          chk_en = 1'b0;
  bit          prev_wave = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected stream of one accepted pass: every read address in order and every buffer write.
  task automatic push_pass();
    bit   bpm;
    wr_t  w;
    logic [11:0] a;
    bpm = (pass_cnt % BPM_EVERY) == 0;
    pass_cnt++;
    for (int i = 0; i < int'(SC); i++) begin
      a = ECG_B + 12'(i);
      q_addr.push_back(a);
      w.sel = 1'b0; w.idx = 9'(i); w.data = mem[a][11:4];
      q_wr.push_back(w);
    end
    for (int i = 0; i < int'(SC); i++) begin
      a = EMG_B + 12'(i);
      q_addr.push_back(a);
      w.sel = 1'b1; w.idx = 9'(i); w.data = mem[a][11:4];
      q_wr.push_back(w);
    end
    if (bpm) q_addr.push_back(BPM_A);
  endtask

  always @(negedge clk) begin
    bit   nxt_wave;
    logic [11:0] ea;
    wr_t  ew;
    if (chk_en) begin
      nxt_wave = 1'b0;
      if (cpu_req || reset) begin
        chk("cpu_grant_on_req", {31'b0, cpu_grant}, 32'd1);
        chk("cpu_addr_pass", {20'b0, mem_addr}, {20'b0, cpu_addr});
      end else if (!cpu_grant) begin
        if (q_addr.size() == 0) begin
          chk("spurious_issue", {20'b0, mem_addr}, 32'hFFFF_FFFF);
        end else begin
          ea = q_addr.pop_front();
          chk("issue_addr", {20'b0, mem_addr}, {20'b0, ea});
          nxt_wave = (ea != BPM_A);
        end
      end else begin
        chk("idle_addr", {20'b0, mem_addr}, {20'b0, cpu_addr});
      end
      chk("buf_we_latency", {31'b0, buf_we}, {31'b0, prev_wave});
      if (buf_we) begin
        if (q_wr.size() == 0) begin
          chk("spurious_write", {23'b0, buf_waddr}, 32'hFFFF_FFFF);
        end else begin
          ew = q_wr.pop_front();
          wr_seen++;
          chk("buf_sel", {31'b0, buf_sel}, {31'b0, ew.sel});
          chk("buf_waddr", {23'b0, buf_waddr}, {23'b0, ew.idx});
          chk("buf_wdata", {24'b0, buf_wdata}, {24'b0, ew.data});
        end
      end
      prev_wave = nxt_wave;
    end
  end

  task automatic run_pass(input int cs, input int cl, input int fs_at, output int cycles);
    @(posedge clk); #1;
    frame_start = 1'b1;
    push_pass();
    @(posedge clk); #1;
    frame_start = 1'b0;
    cycles = 0;
    while (busy && cycles < 2000) begin
      cpu_req     = (cycles >= cs) && (cycles < cs + cl);
      cpu_addr    = 12'h100 + 12'(cycles);
      frame_start = (cycles == fs_at);
      @(posedge clk); #1;
      cycles++;
    end
    cpu_req     = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic chk_digits(input string name, input int v);
    int c;
    c = (v > 999) ? 999 : v;
    chk({name, "_h"}, {28'b0, d_h}, 32'(c / 100));
    chk({name, "_t"}, {28'b0, d_t}, 32'((c / 10) % 10));
    chk({name, "_o"}, {28'b0, d_o}, 32'(c % 10));
  endtask

  initial begin
    int cyc;
    reset = 1'b1; frame_start = 1'b0; cpu_req = 1'b0; cpu_addr = 12'h3C5;
    for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
    for (int i = 0; i < int'(SC); i++) begin
      mem[ECG_B + 12'(i)] = 32'(i) << 4;
      mem[EMG_B + 12'(i)] = 32'hA5A5_0000 | (32'((i * 7 + 3) & 255) << 4) | 32'hF;
    end
    mem[BPM_A] = 32'd72;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_buf_we", {31'b0, buf_we}, 32'd0);
    chk("rst_buf_sel", {31'b0, buf_sel}, 32'd0);
    chk("rst_buf_waddr", {23'b0, buf_waddr}, 32'd0);
    chk("rst_buf_wdata", {24'b0, buf_wdata}, 32'd0);
    chk("rst_digits", {20'b0, d_h, d_t, d_o}, 32'd0);
    chk("rst_valid", {31'b0, bpm_valid}, 32'd0);
    chk("rst_overrun", {31'b0, overrun}, 32'd0);
    chk("rst_grant", {31'b0, cpu_grant}, 32'd1);
    chk("rst_mem_addr", {20'b0, mem_addr}, 32'h3C5);
    reset = 1'b0;
    chk_en = 1'b1;

    // Pass 1 fetches BPM: 72 -> 0/7/2
    run_pass(-1, 0, -1, cyc);
    chk("p1_len_bounds", 32'((cyc >= 674) && (cyc <= 694)), 32'd1);
    chk_digits("p1_bpm", 72);
    chk("p1_digits_lit", {20'b0, d_h, d_t, d_o}, 32'h072);
    chk("p1_valid", {31'b0, bpm_valid}, 32'd1);
    chk("p1_writes", wr_seen, 32'd670);
    chk("p1_overrun", {31'b0, overrun}, 32'd0);
    mem[BPM_A] = 32'd555;

    run_pass(100, 10, -1, cyc);
    chk("p2_len_contended", 32'(cyc), 32'd682);
    chk("p2_writes", wr_seen, 32'd1340);
    for (int p = 3; p <= 60; p++) begin
      run_pass(-1, 0, -1, cyc);
      chk("nobpm_len", 32'(cyc), 32'(2 * SC + 2));
    end
    chk("p60_digits_held", {20'b0, d_h, d_t, d_o}, 32'h072);

    mem[BPM_A] = 32'd1234;
    run_pass(-1, 0, -1, cyc);
    chk("p61_len_bounds", 32'((cyc >= 674) && (cyc <= 694)), 32'd1);
    chk_digits("p61_bpm", 1234);
    chk("p61_digits_lit", {20'b0, d_h, d_t, d_o}, 32'h999);

    // frame_start during FETCH_EMG is ignored but flagged
    run_pass(-1, 0, 500, cyc);
    chk("p62_len_no_restart", 32'(cyc), 32'd672);
    chk("p62_overrun", {31'b0, overrun}, 32'd1);
    repeat (5) @(posedge clk);
    #1;
    chk("p62_overrun_sticky", {31'b0, overrun}, 32'd1);
    chk("p62_idle", {31'b0, busy}, 32'd0);

    // Reset mid-FETCH_EMG
    @(posedge clk); #1;
    frame_start = 1'b1;
    push_pass();
    @(posedge clk); #1;
    frame_start = 1'b0;
    repeat (400) @(posedge clk);
    #1;
    chk("pre_rst_busy", {31'b0, busy}, 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    q_addr.delete();
    q_wr.delete();
    pass_cnt = 0;
    chk("mid_rst_busy", {31'b0, busy}, 32'd0);
    chk("mid_rst_buf_we", {31'b0, buf_we}, 32'd0);
    chk("mid_rst_digits", {20'b0, d_h, d_t, d_o}, 32'd0);
    chk("mid_rst_valid", {31'b0, bpm_valid}, 32'd0);
    chk("mid_rst_overrun", {31'b0, overrun}, 32'd0);
    repeat (3) @(posedge clk);
    #1;

    mem[BPM_A] = 32'd305;
    run_pass(-1, 0, -1, cyc);
    chk("post_rst_len_bounds", 32'((cyc >= 674) && (cyc <= 694)), 32'd1);
    chk_digits("post_rst_bpm", 305);
    chk("post_rst_valid", {31'b0, bpm_valid}, 32'd1);
    chk("post_rst_overrun", {31'b0, overrun}, 32'd0);

    // frame_start in the last busy cycle still counts as busy
    run_pass(-1, 0, 671, cyc);
    chk("coinc_len", 32'(cyc), 32'd672);
    chk("coinc_overrun", {31'b0, overrun}, 32'd1);
    repeat (4) @(posedge clk);
    #1;
    chk("coinc_no_start", {31'b0, busy}, 32'd0);
    chk("final_q_addr_empty", 32'(q_addr.size()), 32'd0);
    chk("final_q_wr_empty", 32'(q_wr.size()), 32'd0);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
